// File: rtl/aes_out_serializer.sv
// Purpose : queue 128-bit AES output blocks and stream each one as four 32-bit words, MSW first.
// Latency : a block captured into an empty queue shows word 0 on ser_valid the next cycle.
// Backpr. : words hold while ser_ready=0; a push attempt while full drops the block and sets overflow.
//
// Ports:
//   AES_clk, AES_rst            clock, asynchronous active-high reset
//   AES_data_out_valid/_out     block strobe and 128-bit block from the AES core
//   ser_valid/ser_ready         word handshake towards the sink
//   ser_data, ser_last          current word, and "this is word 3 of the block"
//   ovf_clr, overflow           clear input and sticky dropped-block flag
//   fifo_count                  blocks held, including the one currently being sent
module aes_out_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     AES_clk,
    input  logic                     AES_rst,
    input  logic                     AES_data_out_valid,
    input  logic [127:0]             AES_data_out,
    input  logic                     ser_ready,
    output logic                     ser_valid,
    output logic [31:0]              ser_data,
    output logic                     ser_last,
    input  logic                     ovf_clr,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    word_idx;
    logic [127:0]  head;

    logic full;
    logic pop;
    logic push;
    logic drop;

    assign full      = (fifo_count == (AW+1)'(DEPTH));
    assign ser_valid = (fifo_count != '0);
    assign ser_last  = ser_valid && (word_idx == 2'd3);

    // A block leaves on acceptance of its last word.
    assign pop  = ser_valid && ser_ready && (word_idx == 2'd3);
    // A pop on the same edge frees a slot, so a full queue still accepts the push.
    assign push = AES_data_out_valid && (!full || pop);
    assign drop = AES_data_out_valid && full && !pop;

    assign head = mem[rd_ptr];

    // Output is forced to zero when nothing is queued so reset presents ser_data=0
    // without having to clear the storage array.
    always_comb begin
        ser_data = '0;
        if (ser_valid) begin
            case (word_idx)
                2'd0:    ser_data = head[127:96];
                2'd1:    ser_data = head[95:64];
                2'd2:    ser_data = head[63:32];
                default: ser_data = head[31:0];
            endcase
        end
    end

    always_ff @(posedge AES_clk) begin
        if (push) begin
            mem[wr_ptr] <= AES_data_out;
        end
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_idx   <= 2'd0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end

            if (ser_valid && ser_ready) begin
                // word_idx wraps 3 -> 0 naturally on the final word
                word_idx <= word_idx + 2'd1;
                if (word_idx == 2'd3) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            // A drop on the same edge as ovf_clr keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
